// File: rtl/adder_tree_scheduler_if.sv
// rtl/adder_tree_scheduler_if.sv - beat input, external tree and result signals of adder_tree_scheduler
interface adder_tree_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8,
  parameter int MAX_BEATS  = 16
);
  localparam int TREE_WIDTH = DATA_WIDTH + $clog2(LANES);
  localparam int ACC_WIDTH  = TREE_WIDTH + $clog2(MAX_BEATS);
  localparam int CNT_WIDTH  = $clog2(MAX_BEATS) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data [LANES];
  logic                  in_last;
  logic [DATA_WIDTH-1:0] tree_addends [LANES];
  logic [TREE_WIDTH-1:0] tree_sum;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_sum;
  logic [CNT_WIDTH-1:0]  out_beats;
  logic                  out_overflow;

  modport slave (
    input  in_valid, in_data, in_last, tree_sum, out_ready,
    output in_ready, tree_addends, out_valid, out_sum, out_beats, out_overflow
  );

  modport master (
    output in_valid, in_data, in_last, tree_sum, out_ready,
    input  in_ready, tree_addends, out_valid, out_sum, out_beats, out_overflow
  );
endinterface

// File: rtl/adder_tree_scheduler.sv
// rtl/adder_tree_scheduler.sv - per-job beat accumulator feeding an external adder tree
// Optional feature macro: ADDER_TREE_SCHEDULER_SATURATE_EN (saturating accumulator)
module adder_tree_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8,
  parameter int MAX_BEATS  = 16
) (
  input logic                   clk,
  input logic                   rst,
  adder_tree_scheduler_if.slave bus
);
  localparam int TREE_WIDTH = DATA_WIDTH + $clog2(LANES);
  localparam int ACC_WIDTH  = TREE_WIDTH + $clog2(MAX_BEATS);
  localparam int CNT_WIDTH  = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_BEATS);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] beat_reg [LANES];
  logic                  beat_vld;
  logic                  beat_first;
  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH-1:0]  tree_ext;
  logic [CNT_WIDTH-1:0]  count;
  logic                  cnt_ovf;
  logic                  ready;
  logic                  accept;

  assign ready    = (state == IDLE) || (state == ACCUM);
  assign accept   = bus.in_valid && ready;
  assign tree_ext = {{(ACC_WIDTH - TREE_WIDTH){1'b0}}, bus.tree_sum};

`ifdef ADDER_TREE_SCHEDULER_SATURATE_EN
  logic                 sat_ovf;
  logic [ACC_WIDTH:0]   acc_sum;
  logic [ACC_WIDTH-1:0] acc_next;
  assign acc_sum  = {1'b0, acc} + {1'b0, tree_ext};
  assign acc_next = acc_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : acc_sum[ACC_WIDTH-1:0];
  assign bus.out_overflow = cnt_ovf || sat_ovf;
`else
  logic [ACC_WIDTH-1:0] acc_next;
  assign acc_next = acc + tree_ext;
  assign bus.out_overflow = cnt_ovf;
`endif

  assign bus.in_ready     = ready;
  assign bus.out_valid    = (state == DONE);
  assign bus.out_sum      = acc;
  assign bus.out_beats    = count;
  assign bus.tree_addends = beat_reg;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = bus.in_last ? FLUSH : ACCUM;
      ACCUM:   if (accept && bus.in_last) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat_vld   <= 1'b0;
      beat_first <= 1'b0;
      acc        <= '0;
      count      <= '0;
      cnt_ovf    <= 1'b0;
      for (int i = 0; i < LANES; i++) beat_reg[i] <= '0;
`ifdef ADDER_TREE_SCHEDULER_SATURATE_EN
      sat_ovf    <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      beat_vld   <= accept;
      beat_first <= accept && (state == IDLE);
      for (int i = 0; i < LANES; i++) beat_reg[i] <= accept ? bus.in_data[i] : '0;

      // A job's flags restart with its first beat, not at handshake, so the result stays intact until then
      if (accept) begin
        if (state == IDLE) begin
          count   <= CNT_WIDTH'(1);
          cnt_ovf <= 1'b0;
`ifdef ADDER_TREE_SCHEDULER_SATURATE_EN
          sat_ovf <= 1'b0;
`endif
        end else if (count == CNT_MAX) begin
          count   <= CNT_MAX + CNT_WIDTH'(1);
          cnt_ovf <= 1'b1;
        end else if (count < CNT_MAX) begin
          count   <= count + CNT_WIDTH'(1);
        end
      end

      if (beat_vld) begin
        if (beat_first) begin
          acc <= tree_ext;
        end else begin
          acc <= acc_next;
`ifdef ADDER_TREE_SCHEDULER_SATURATE_EN
          if (acc_sum[ACC_WIDTH]) sat_ovf <= 1'b1;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_adder_tree_scheduler.sv
// tb/tb_adder_tree_scheduler.sv - scoreboard bench for adder_tree_scheduler
module tb_adder_tree_scheduler;
  localparam int DW = 8;
  localparam int LN = 8;
  localparam int MB = 16;
  localparam int TW = DW + $clog2(LN);
  localparam int AW = TW + $clog2(MB);
  localparam int CW = $clog2(MB) + 1;
  localparam longint ACC_MAX = (64'd1 << AW) - 1;

  typedef logic [DW-1:0] beat_t [LN];
  typedef struct {
    longint sum;
    int     beats;
    bit     ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [TW-1:0] tree_acc;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  longint m_sum;
  int m_beats = 0;
  bit m_cnt_ovf;
  bit m_sat;

  always #5 clk = ~clk;

  adder_tree_scheduler_if #(.DATA_WIDTH(DW), .LANES(LN), .MAX_BEATS(MB)) bus();

  adder_tree_scheduler #(.DATA_WIDTH(DW), .LANES(LN), .MAX_BEATS(MB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // external combinational adder tree
  always_comb begin
    tree_acc = '0;
    for (int i = 0; i < LN; i++) tree_acc = tree_acc + TW'(bus.tree_addends[i]);
  end
  assign bus.tree_sum = tree_acc;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t fill(input int v);
    beat_t d;
    for (int i = 0; i < LN; i++) d[i] = DW'(v);
    return d;
  endfunction

  task automatic model_beat(input beat_t d, input bit last);
    longint bsum = 0;
    for (int i = 0; i < LN; i++) bsum += longint'(d[i]);
    if (m_beats == 0) begin
      m_sum = bsum; m_beats = 1; m_cnt_ovf = 0; m_sat = 0;
    end else begin
      m_sum += bsum;
`ifdef ADDER_TREE_SCHEDULER_SATURATE_EN
      if (m_sum > ACC_MAX) begin m_sum = ACC_MAX; m_sat = 1; end
`else
      m_sum = m_sum & ACC_MAX;
`endif
      if (m_beats == MB) begin m_beats = MB + 1; m_cnt_ovf = 1; end
      else if (m_beats < MB) m_beats++;
    end
    if (last) begin
      sb.push_back('{m_sum, m_beats, m_cnt_ovf || m_sat});
      m_beats = 0;
    end
  endtask

  task automatic send_beat(input beat_t d, input bit last, output int stalls);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    stalls = 0;
    while (!bus.in_ready && stalls < 50) begin tick(); stalls++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, stalls);
    end else begin
      model_beat(d, last);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic collect(input string name, input int hold);
    int waited = 0;
    exp_t e;
    logic [AW-1:0] s0;
    while (!bus.out_valid && waited < 40) begin tick(); waited++; end
    checks++;
    if (!bus.out_valid) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%0b, required 1", name, bus.out_valid);
      return;
    end
    if (hold > 0) begin
      s0 = bus.out_sum;
      bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.in_data = fill(77);
      for (int k = 0; k < hold; k++) begin
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== s0 || bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s_hold: out_valid=%0b out_sum=%0d in_ready=%0b, required 1 %0d 0",
                   name, bus.out_valid, bus.out_sum, bus.in_ready, s0);
        end
      end
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected: result with empty scoreboard, out_sum=%0d", name, bus.out_sum);
    end else begin
      e = sb.pop_front();
      checks += 3;
      if (bus.out_sum !== AW'(e.sum)) begin
        errors++; $display("FAIL %s_sum: got %0d, required %0d", name, bus.out_sum, e.sum);
      end
      if (bus.out_beats !== CW'(e.beats)) begin
        errors++; $display("FAIL %s_beats: got %0d, required %0d", name, bus.out_beats, e.beats);
      end
      if (bus.out_overflow !== e.ovf) begin
        errors++; $display("FAIL %s_overflow: got %0b, required %0b", name, bus.out_overflow, e.ovf);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: out_valid=%0b in_ready=%0b, required 0 1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    bit nz = 0;
    for (int i = 0; i < LN; i++) if (bus.tree_addends[i] !== '0) nz = 1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sum !== '0 ||
        bus.out_beats !== '0 || bus.out_overflow !== 1'b0 || nz) begin
      errors++;
      $display("FAIL %s: in_ready=%0b out_valid=%0b out_sum=%0d out_beats=%0d ovf=%0b addends_nz=%0b, required 1 0 0 0 0 0",
               name, bus.in_ready, bus.out_valid, bus.out_sum, bus.out_beats, bus.out_overflow, nz);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0; bus.in_data = fill(0);
    tick(); tick();
    check_idle_outputs("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_single;
    beat_t d;
    int st;
    for (int i = 0; i < LN; i++) d[i] = DW'(i + 1);
    send_beat(d, 1'b1, st);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.tree_addends[7] !== DW'(8)) begin
      errors++;
      $display("FAIL single_flush: out_valid=%0b in_ready=%0b addend7=%0d, required 0 0 8",
               bus.out_valid, bus.in_ready, bus.tree_addends[7]);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL single_latency: out_valid=%0b, required 1", bus.out_valid);
    end
    collect("single", 0);
  endtask

  task automatic test_back_to_back;
    int st;
    int total = 0;
    for (int b = 0; b < 4; b++) begin
      send_beat(fill(255), b == 3, st);
      total += st;
    end
    checks++;
    if (total !== 0) begin
      errors++; $display("FAIL b2b_stalls: got %0d stall cycles, required 0", total);
    end
    collect("b2b", 0);
  endtask

  task automatic test_hold;
    int st;
    send_beat(fill(3), 1'b1, st);
    collect("hold", 5);
  endtask

  task automatic test_overflow;
    int st;
    for (int b = 0; b < 17; b++) send_beat(fill(255), b == 16, st);
    collect("overflow", 0);
  endtask

  task automatic test_reset_mid;
    int st;
    send_beat(fill(200), 1'b0, st);
    send_beat(fill(200), 1'b0, st);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_beats = 0;
    check_idle_outputs("reset_mid_state");
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_mid_spurious: out_valid=%0b, required 0", bus.out_valid);
      end
    end
    send_beat(fill(1), 1'b1, st);
    collect("reset_mid", 0);
  endtask

  task automatic test_gaps;
    int st;
    for (int b = 0; b < 3; b++) begin
      send_beat(fill(10), b == 2, st);
      if (b < 2) begin bus.in_data = fill(99); tick(); tick(); end
    end
    collect("gaps", 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_overflow();
    test_reset_mid();
    test_gaps();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
